// File: rtl/oai_grp_pipe.sv
// oai_grp_pipe: elastic STAGES-deep pipeline computing ZN = ~&(|group) over GROUPS groups of WIDTH bits,
// plus a saturating count of delivered ZN=0 results.
module oai_grp_pipe #(
  parameter int GROUPS = 3,
  parameter int WIDTH  = 2,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RN,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [GROUPS*WIDTH-1:0]   A,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      ZN,
  input  logic                      CLR,
  output logic [CNT_W-1:0]          CNT
);
  logic [GROUPS-1:0] grp;
  logic [STAGES-1:0] v, rdy, up_v;
  logic              fin_in;
  always_comb begin
    grp = '0;
    for (int g = 0; g < GROUPS; g++) grp[g] = |A[g*WIDTH +: WIDTH];
  end
  // valid bit feeding each stage: IN_VALID for the first, the previous stage otherwise
  assign up_v = STAGES'({v, IN_VALID});
  // a stage can take an item if it is empty or its occupant moves on this cycle
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = ~v[STAGES-1] | OUT_READY;
    for (int k = STAGES - 2; k >= 0; k--) rdy[k] = ~v[k] | rdy[k+1];
  end
  assign IN_READY  = rdy[0];
  assign OUT_VALID = v[STAGES-1];
  always_ff @(posedge CLK or negedge RN)
    if (!RN) v <= '0;
    else for (int k = 0; k < STAGES; k++) if (rdy[k]) v[k] <= up_v[k];
  generate
    if (STAGES == 1) begin : g_direct
      assign fin_in = ~&grp;
    end else begin : g_vec
      logic [GROUPS-1:0] vec [STAGES-1];
      always_ff @(posedge CLK or negedge RN)
        if (!RN) begin
          for (int k = 0; k < STAGES - 1; k++) vec[k] <= '0;
        end else begin
          if (rdy[0] && IN_VALID) vec[0] <= grp;
          for (int k = 1; k < STAGES - 1; k++) if (rdy[k] && v[k-1]) vec[k] <= vec[k-1];
        end
      assign fin_in = ~&vec[STAGES-2];
    end
  endgenerate
  always_ff @(posedge CLK or negedge RN)
    if (!RN) ZN <= 1'b0;
    else if (rdy[STAGES-1] && up_v[STAGES-1]) ZN <= fin_in;
  always_ff @(posedge CLK or negedge RN)
    if (!RN) CNT <= '0;
    else if (CLR) CNT <= '0;
    else if (OUT_VALID && OUT_READY && !ZN && !(&CNT)) CNT <= CNT + 1'b1;
endmodule
